// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared bus definitions: port codes, port count, sequencer states.
package bus_pkg;

   localparam int NUM_BUS_PORTS = 24;

   typedef logic [4:0] code_t;

   // Source codes (drive the bus)
   localparam code_t SRC_R0      = 5'd0;
   localparam code_t SRC_R15     = 5'd15;
   localparam code_t SRC_HI      = 5'd16;
   localparam code_t SRC_LO      = 5'd17;
   localparam code_t SRC_ZHI     = 5'd18;
   localparam code_t SRC_ZLO     = 5'd19;
   localparam code_t SRC_PC      = 5'd20;
   localparam code_t SRC_MDR     = 5'd21;
   localparam code_t SRC_INPORT  = 5'd22;
   localparam code_t SRC_C_SEXT  = 5'd23;

   // Destination codes (load from the bus)
   localparam code_t DST_R0      = 5'd0;
   localparam code_t DST_R15     = 5'd15;
   localparam code_t DST_HI      = 5'd16;
   localparam code_t DST_LO      = 5'd17;
   localparam code_t DST_Z       = 5'd18;
   localparam code_t DST_Y       = 5'd19;
   localparam code_t DST_PC      = 5'd20;
   localparam code_t DST_MDR     = 5'd21;
   localparam code_t DST_MAR     = 5'd22;
   localparam code_t DST_OUTPORT = 5'd23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_LATCH,
      ST_DONE,
      ST_ERR
   } state_t;

   function automatic logic code_in_range(input code_t code);
      return code < code_t'(NUM_BUS_PORTS);
   endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake plus bus enable/status signals of the transfer sequencer.
interface bus_xfer_sequencer_if;
   import bus_pkg::*;

   logic                     req_valid;
   logic                     req_ready;
   code_t                    req_src;
   code_t                    req_dst;
   logic [NUM_BUS_PORTS-1:0] src_oe;
   logic [NUM_BUS_PORTS-1:0] dst_we;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic [7:0]               xfer_count;

   modport master (
      output req_valid, req_src, req_dst,
      input  req_ready, src_oe, dst_we, busy, done, err, xfer_count
   );

   modport slave (
      input  req_valid, req_src, req_dst,
      output req_ready, src_oe, dst_we, busy, done, err, xfer_count
   );

endinterface

// File: rtl/bus_xfer_sequencer_decoder.sv
// 5-bit bus code to one-hot enable vector; out-of-range codes give all zeros.
module onehot_decoder
   import bus_pkg::*;
(
   input  code_t                    code,
   output logic [NUM_BUS_PORTS-1:0] onehot,
   output logic                     in_range
);

   // Set the single bit selected by the code when it names a real port
   always_comb begin
      onehot   = '0;
      in_range = code_in_range(code);
      if (in_range) begin
         onehot[code] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences one register-to-register bus transfer: drive, latch, done.
module bus_xfer_sequencer
   import bus_pkg::*;
(
   input  logic                 clock,
   input  logic                 clear,
   bus_xfer_sequencer_if.slave  bus
);

   state_t                   state;
   state_t                   state_next;
   code_t                    src_q;
   code_t                    dst_q;
   logic [7:0]               count_q;
   logic [NUM_BUS_PORTS-1:0] src_vec;
   logic [NUM_BUS_PORTS-1:0] dst_vec;
   logic                     src_ok;
   logic                     dst_ok;
   logic                     accept;

   // Enables are decoded only from the held codes, so request inputs never
   // reach src_oe/dst_we combinationally.
   onehot_decoder u_src_dec (
      .code     (src_q),
      .onehot   (src_vec),
      .in_range (src_ok)
   );

   onehot_decoder u_dst_dec (
      .code     (dst_q),
      .onehot   (dst_vec),
      .in_range (dst_ok)
   );

   assign accept         = bus.req_valid && (state == ST_IDLE);
   assign bus.xfer_count = count_q;

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the request codes on acceptance only
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         src_q <= '0;
         dst_q <= '0;
      end else if (accept) begin
         src_q <= bus.req_src;
         dst_q <= bus.req_dst;
      end
   end

   // Completed-transfer counter, bumped as LATCH hands over to DONE
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count_q <= '0;
      end else if (state == ST_LATCH) begin
         count_q <= count_q + 8'd1;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_next    = state;
      bus.req_ready = 1'b0;
      bus.busy      = 1'b1;
      bus.src_oe    = '0;
      bus.dst_we    = '0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.req_valid) begin
               if (code_in_range(bus.req_src) && code_in_range(bus.req_dst)) begin
                  state_next = ST_DRIVE;
               end else begin
                  state_next = ST_ERR;
               end
            end
         end
         ST_DRIVE: begin
            bus.src_oe = src_ok ? src_vec : '0;
            state_next = ST_LATCH;
         end
         ST_LATCH: begin
            bus.src_oe = src_ok ? src_vec : '0;
            bus.dst_we = dst_ok ? dst_vec : '0;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            bus.done   = 1'b1;
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            bus.err    = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer: timeline model plus directed vectors.
module tb_bus_xfer_sequencer;
   import bus_pkg::*;

   logic clock;
   logic clear;

   bus_xfer_sequencer_if bus ();

   bus_xfer_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total;
   int bad;

   // Timeline model: expected outputs per cycle, kept in a small ring
   int          t;
   int          free_at;
   logic [23:0] e_oe   [8];
   logic [23:0] e_we   [8];
   logic        e_done [8];
   logic        e_err  [8];
   logic [7:0]  e_cnt;
   int          acc_log[$];
   int          n_done_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      t       = 0;
      free_at = 0;
      e_cnt   = 8'd0;
      for (int i = 0; i < 8; i++) begin
         e_oe[i]   = '0;
         e_we[i]   = '0;
         e_done[i] = 1'b0;
         e_err[i]  = 1'b0;
      end
   endtask

   // Applies the rules at a rising edge: a request is taken when the
   // sequencer has been idle long enough; a valid one occupies 3 cycles
   // (drive, latch, done), a bad one 1 cycle (err).
   task automatic model_edge();
      int   s;
      int   d;
      logic acc;
      if (!clear) begin
         model_reset();
         return;
      end
      acc = bus.req_valid && (t >= free_at);
      s   = int'(bus.req_src);
      d   = int'(bus.req_dst);
      e_oe[t % 8]   = '0;
      e_we[t % 8]   = '0;
      e_done[t % 8] = 1'b0;
      e_err[t % 8]  = 1'b0;
      if (acc) acc_log.push_back(t);
      t++;
      if (acc) begin
         if (s < 24 && d < 24) begin
            e_oe[t % 8]         = 24'(1) << s;
            e_oe[(t + 1) % 8]   = 24'(1) << s;
            e_we[(t + 1) % 8]   = 24'(1) << d;
            e_done[(t + 2) % 8] = 1'b1;
            free_at             = t + 3;
         end else begin
            e_err[t % 8] = 1'b1;
            free_at      = t + 1;
         end
      end
      if (e_done[t % 8]) e_cnt = e_cnt + 8'd1;
   endtask

   task automatic compare_all();
      int   k;
      logic exp_ready;
      k         = t % 8;
      exp_ready = (t >= free_at);
      check("src_oe",     32'(bus.src_oe),     32'(e_oe[k]));
      check("dst_we",     32'(bus.dst_we),     32'(e_we[k]));
      check("done",       32'(bus.done),       32'(e_done[k]));
      check("err",        32'(bus.err),        32'(e_err[k]));
      check("req_ready",  32'(bus.req_ready),  32'(exp_ready));
      check("busy",       32'(bus.busy),       32'(!exp_ready));
      check("xfer_count", 32'(bus.xfer_count), 32'(e_cnt));
      check("oe_onehot",  32'($countones(bus.src_oe) <= 1), 1);
      check("we_onehot",  32'($countones(bus.dst_we) <= 1), 1);
      if (bus.done === 1'b1) n_done_seen++;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) cycle();
   endtask

   // Present a request and hold valid until it is taken (bounded)
   task automatic send(input logic [4:0] s, input logic [4:0] d);
      int n;
      n = acc_log.size();
      bus.req_src   = s;
      bus.req_dst   = d;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 8 && acc_log.size() == n; i++) cycle();
      check("accept_timeout", 32'(acc_log.size()), 32'(n + 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int d0;
      total         = 0;
      bad           = 0;
      n_done_seen   = 0;
      clear         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_src   = '0;
      bus.req_dst   = '0;
      model_reset();

      // Reset state
      cycle();
      cycle();
      check("rst_count", 32'(bus.xfer_count), 0);
      check("rst_oe",    32'(bus.src_oe), 0);
      check("rst_we",    32'(bus.dst_we), 0);
      check("rst_ready", 32'(bus.req_ready), 1);
      check("rst_busy",  32'(bus.busy), 0);
      clear = 1'b1;

      // Normal transfer R4 -> PCin, accepted on first edge after reset release
      bus.req_src   = 5'd4;
      bus.req_dst   = 5'd20;
      bus.req_valid = 1'b1;
      cycle();
      bus.req_valid = 1'b0;
      check("first_accept", 32'(acc_log.size()), 1);
      check("n_oe_c1", 32'(bus.src_oe), 32'h000010);
      check("n_we_c1", 32'(bus.dst_we), 32'h000000);
      cycle();
      check("n_oe_c2", 32'(bus.src_oe), 32'h000010);
      check("n_we_c2", 32'(bus.dst_we), 32'h100000);
      cycle();
      check("n_done_c3", 32'(bus.done), 1);
      check("n_cnt_c3",  32'(bus.xfer_count), 1);
      cycle();
      check("n_ready_c4", 32'(bus.req_ready), 1);

      // Invalid source code
      bus.req_src   = 5'd25;
      bus.req_dst   = 5'd3;
      bus.req_valid = 1'b1;
      cycle();
      bus.req_valid = 1'b0;
      check("inv_err", 32'(bus.err), 1);
      check("inv_oe",  32'(bus.src_oe), 0);
      cycle();
      check("inv_ready", 32'(bus.req_ready), 1);
      check("inv_cnt",   32'(bus.xfer_count), 1);

      // Highest legal code, bad destination, same register both sides
      send(5'd23, 5'd23);
      check("b23_oe", 32'(bus.src_oe), 32'h800000);
      idle(3);
      send(5'd2, 5'd31);
      check("dst_bad_err", 32'(bus.err), 1);
      idle(1);
      send(5'd5, 5'd5);
      cycle();
      check("same_we", 32'(bus.dst_we), 32'h000020);
      idle(2);
      check("same_cnt", 32'(bus.xfer_count), 3);

      // Back-to-back with valid held high
      base = acc_log.size();
      d0   = n_done_seen;
      send(5'd1, 5'd2);
      send(5'd3, 5'd4);
      send(5'd6, 5'd7);
      idle(4);
      check("b2b_gap1", 32'(acc_log[base + 1] - acc_log[base]), 4);
      check("b2b_gap2", 32'(acc_log[base + 2] - acc_log[base + 1]), 4);
      check("b2b_done", 32'(n_done_seen - d0), 3);
      check("b2b_cnt",  32'(bus.xfer_count), 6);

      // Back-to-back rejections
      base = acc_log.size();
      send(5'd24, 5'd0);
      send(5'd0, 5'd30);
      idle(2);
      check("err_gap", 32'(acc_log[base + 1] - acc_log[base]), 2);

      // Inputs changed while busy are ignored
      send(5'd7, 5'd9);
      base          = acc_log.size();
      bus.req_src   = 5'd1;
      bus.req_dst   = 5'd2;
      bus.req_valid = 1'b1;
      cycle();
      check("ign_oe", 32'(bus.src_oe), 32'h000080);
      check("ign_we", 32'(bus.dst_we), 32'h000200);
      idle(3);
      check("ign_noacc", 32'(acc_log.size()), 32'(base));
      check("ign_cnt",   32'(bus.xfer_count), 7);

      // Reset during LATCH aborts the transfer
      send(5'd3, 5'd10);
      cycle();
      check("mr_we_pre", 32'(bus.dst_we), 32'h000400);
      clear = 1'b0;
      #1;
      check("mr_oe_async", 32'(bus.src_oe), 0);
      check("mr_we_async", 32'(bus.dst_we), 0);
      check("mr_cnt",      32'(bus.xfer_count), 0);
      model_reset();
      compare_all();
      d0 = n_done_seen;
      #2;
      clear = 1'b1;
      send(5'd0, 5'd0);
      idle(3);
      check("mr_done", 32'(n_done_seen - d0), 1);
      check("mr_cnt2", 32'(bus.xfer_count), 1);

      // Counter wrap after 256 transfers from reset
      clear = 1'b0;
      model_reset();
      cycle();
      clear = 1'b1;
      d0 = n_done_seen;
      for (int i = 0; i < 256; i++) begin
         send(5'(i % 24), 5'((i * 7 + 3) % 24));
         if (i == 255) check("wrap_pre", 32'(bus.xfer_count), 255);
      end
      idle(4);
      check("wrap_cnt",  32'(bus.xfer_count), 0);
      check("wrap_done", 32'(n_done_seen - d0), 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_xfer_sequencer.md
BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports are listed below, clock and reset first.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 clear  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  a transfer request is present.
REQ-005 req_ready  out  1  the sequencer accepts a request this cycle.
REQ-006 req_src  in  5  bus source code: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C-sign-extended.
REQ-007 req_dst  in  5  bus destination code: 0-15 R0in-R15in, 16 HIin, 17 LOin, 18 Zin, 19 Yin, 20 PCin, 21 MDRin, 22 MARin, 23 OutPortin.
REQ-008 src_oe  out  24  one-hot out-enables; bit n matches source code n and feeds the bus-mux encoder.
REQ-009 dst_we  out  24  one-hot register load-enables; bit n matches destination code n.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when a transfer completes.
REQ-012 err  out  1  one-cycle pulse when a request is rejected.
REQ-013 xfer_count  out  8  number of completed transfers; wraps from 255 to 0.

Function
REQ-014 SHALL implement the states IDLE, DRIVE, LATCH, DONE and ERR.
REQ-015 req_ready SHALL equal (state==IDLE); a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-016 On acceptance, SHALL capture req_src and req_dst into internal holding registers; later changes on the request inputs SHALL have no effect.
REQ-017 Accepted request with both codes <=23: IDLE->DRIVE.
REQ-018 Accepted request with either code >23: IDLE->ERR.
REQ-019 DRIVE: src_oe[src]=1 and dst_we=0; this cycle lets the bus settle; next state is LATCH.
REQ-020 LATCH: src_oe[src]=1 and dst_we[dst]=1 for exactly one cycle; next state is DONE.
REQ-021 DONE: all enables 0, done=1, xfer_count increments by 1; next state is IDLE.
REQ-022 ERR: all enables 0, err=1, xfer_count unchanged; next state is IDLE.
REQ-023 Latency, with acceptance at edge k:
- src_oe is high in cycles k+1 and k+2.
- dst_we is high in cycle k+2.
- done is high in cycle k+3.
- req_ready is high again in cycle k+4.
REQ-024 src_oe and dst_we SHALL each have at most one bit set in every cycle, including the cycles just after reset.
REQ-025 src==dst index (for example R5->R5) SHALL be legal and follow the normal sequence.
REQ-026 req_valid held high continuously: requests SHALL be accepted back-to-back, one every 4 cycles (valid) or every 2 cycles (ERR path).
REQ-027 req_valid while busy: the request SHALL be ignored (not queued).
REQ-028 Requester obligation: hold req_valid until req_ready is high.
REQ-029 All outputs SHALL be driven from registers or from decoded state; no combinational path from req_* to src_oe or dst_we.

Reset
REQ-030 clear low SHALL asynchronously force:
- state=IDLE
- src_oe=0, dst_we=0
- done=0, err=0, busy=0
- xfer_count=0
- holding registers=0
REQ-031 clear asserted during DRIVE or LATCH SHALL abort the transfer immediately with no dst_we pulse and no done pulse.
REQ-032 The first acceptance SHALL be possible on the first rising edge after clear deasserts.

Structure
REQ-033 A shared package bus_pkg SHALL hold:
- the 5-bit source and destination code constants;
- NUM_BUS_PORTS=24;
- the state enumeration.
REQ-034 A single sub-module onehot_decoder SHALL convert a 5-bit code into a 24-bit one-hot vector plus an in_range flag.
REQ-035 The sequencer SHALL instantiate onehot_decoder twice: once for the source code, once for the destination code.

Verification
REQ-036 Normal transfer: src=4, dst=20 accepted at edge 0 -> src_oe=0x000010 in cycles 1-2; dst_we=0x100000 in cycle 2 only; done in cycle 3; xfer_count=1.
REQ-037 Invalid code: src=25, dst=3 -> err pulse in cycle 1; src_oe and dst_we stay 0; xfer_count unchanged; req_ready high in cycle 2.
REQ-038 Back-to-back: three valid requests with req_valid held high -> accepted at edges 0, 4 and 8; exactly three done pulses; xfer_count=3.
REQ-039 Mid-operation reset: clear pulsed low during LATCH -> enables drop to 0 asynchronously; no done pulse; xfer_count=0; next request accepted normally.
REQ-040 Wrap-around: 256 valid transfers -> xfer_count returns to 0; the one-hot check holds on every cycle.
REQ-041 Ignored input: change req_src/req_dst during DRIVE -> the original src_oe/dst_we bits are used; the mid-transfer request is not accepted.
